// File: rtl/flt2int_core.sv
// flt2int_core: converts an IEEE-754 binary16 operand held in the internal byte memory DM1
// to a saturated signed 16-bit integer. Optional macro SAT_FLAG_EN adds a status byte at OUT_ADDR+2.

module flt2int_dm #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // No reset here: memory contents survive Reset.
    logic [7:0] core [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            core[waddr] <= wdata;
    end

    assign rdata = core[raddr];

endmodule

module flt2int_core #(
    parameter int MEM_DEPTH = 256,
    parameter int IN_ADDR   = 4,
    parameter int OUT_ADDR  = 6
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Done
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] IN_LO  = AW'(IN_ADDR);
    localparam logic [AW-1:0] IN_HI  = AW'(IN_ADDR + 1);
    localparam logic [AW-1:0] OUT_LO = AW'(OUT_ADDR);
    localparam logic [AW-1:0] OUT_HI = AW'(OUT_ADDR + 1);
`ifdef SAT_FLAG_EN
    localparam logic [AW-1:0] OUT_FL = AW'(OUT_ADDR + 2);
`endif

    typedef enum logic [3:0] {
        IDLE, ARM, LD_LO, LD_HI, DECODE, SHIFT, ROUND, ST_LO, ST_HI,
`ifdef SAT_FLAG_EN
        ST_FLAG,
`endif
        FIN
    } state_t;

    state_t      state;
    logic [15:0] half;
    logic        sign;
    logic        is_sat;
    logic        is_zero;
    logic [25:0] acc;
    logic [3:0]  cnt;
    logic [15:0] result;
    logic        done_q;
`ifdef SAT_FLAG_EN
    logic        nonzero;
`endif

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [15:0]   mag;

    flt2int_dm #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) DM1 (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // acc holds M * 2^(E+1); bits 25:11 are the integer part and bit 10 the half bit.
    assign mag = {1'b0, acc[25:11]} + {15'b0, acc[10]};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = OUT_LO;
        mem_wdata = result[7:0];
        mem_raddr = IN_LO;
        case (state)
            LD_HI: mem_raddr = IN_HI;
            ST_LO: mem_we = 1'b1;
            ST_HI: begin
                mem_we    = 1'b1;
                mem_waddr = OUT_HI;
                mem_wdata = result[15:8];
            end
`ifdef SAT_FLAG_EN
            ST_FLAG: begin
                mem_we    = 1'b1;
                mem_waddr = OUT_FL;
                mem_wdata = is_sat ? 8'h01 : ((nonzero && result == 16'h0000) ? 8'h02 : 8'h00);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            half    <= '0;
            sign    <= 1'b0;
            is_sat  <= 1'b0;
            is_zero <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            done_q  <= 1'b0;
`ifdef SAT_FLAG_EN
            nonzero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (Start) begin
                        state  <= ARM;
                        done_q <= 1'b0;
                    end
                end
                ARM:   if (!Start) state <= LD_LO;
                LD_LO: begin
                    half[7:0] <= mem_rdata;
                    state     <= LD_HI;
                end
                LD_HI: begin
                    half[15:8] <= mem_rdata;
                    state      <= DECODE;
                end
                DECODE: begin
                    sign    <= half[15];
                    is_sat  <= half[14:10] >= 5'd30;
                    is_zero <= half[14:10] < 5'd14;
                    acc     <= {15'b0, (half[14:10] != 5'd0), half[9:0]};
                    cnt     <= (half[14:10] >= 5'd14 && half[14:10] < 5'd30) ? 4'(half[14:10] - 5'd14) : 4'd0;
`ifdef SAT_FLAG_EN
                    nonzero <= half[14:0] != 15'd0;
`endif
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (cnt != 4'd0) begin
                        acc <= acc << 1;
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (is_sat)
                        result <= sign ? 16'h8000 : 16'h7FFF;
                    else if (is_zero)
                        result <= 16'h0000;
                    else
                        result <= sign ? (16'h0000 - mag) : mag;
                    state <= ST_LO;
                end
                ST_LO: state <= ST_HI;
`ifdef SAT_FLAG_EN
                ST_HI: state <= ST_FLAG;
                ST_FLAG: begin
                    state  <= FIN;
                    done_q <= 1'b1;
                end
`else
                ST_HI: begin
                    state  <= FIN;
                    done_q <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign Done = done_q;

endmodule

// File: tb/tb_flt2int_core.sv
// Directed self-checking bench for flt2int_core: hand-computed binary16 vectors,
// handshake behaviour, reset abort and memory isolation.

module tb_flt2int_core;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic done;

    int testCount = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    flt2int_core dut (
        .Clk   (clock),
        .Reset (reset),
        .Start (start),
        .Done  (done)
    );

    localparam int NVEC = 21;
    logic [15:0] vecIn  [NVEC] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4B00, 16'h4B80, 16'h7780,
                                   16'h77FF, 16'h7B80, 16'hFB80, 16'h7C00, 16'h8000, 16'hBC00,
                                   16'hBD00, 16'hC880, 16'h3E00, 16'h3800, 16'h3400, 16'h4040,
                                   16'hC100, 16'h3BFF, 16'h0001};
    logic [15:0] vecOut [NVEC] = '{16'h0001, 16'h0002, 16'h0003, 16'h000E, 16'h000F, 16'h7800,
                                   16'h7FF0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF,
                                   16'hFFFF, 16'hFFF7, 16'h0002, 16'h0001, 16'h0000, 16'h0002,
                                   16'hFFFD, 16'h0001, 16'h0000};

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic loadInput(input logic [15:0] value);
        @(negedge clock);
        dut.DM1.core[4] <= value[7:0];
        dut.DM1.core[5] <= value[15:8];
    endtask

    task automatic waitDone(output int latency);
        latency = 0;
        while (!done && latency < 40) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value);
        int latency;
        loadInput(value);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(latency);
    endtask

    task automatic convert(input string tag, input logic [15:0] value, input logic [15:0] expected);
        applyStimulus(value);
        checkOutput({tag, "_done"}, {15'b0, done}, 16'h0001);
        checkOutput(tag, {dut.DM1.core[7], dut.DM1.core[6]}, expected);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int latency;
        int bad;
        logic sawDone;

        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++)
            dut.DM1.core[i] <= 8'(i) ^ 8'hA5;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_done", {15'b0, done}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("idle_done", {15'b0, done}, 16'h0000);

        for (int i = 0; i < NVEC; i++)
            convert($sformatf("vec%0d_%04h", i, vecIn[i]), vecIn[i], vecOut[i]);

        // Back-to-back: Done must drop on the edge that samples the new Start.
        loadInput(16'h4B80);
        start = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("b2b_done_drop", {15'b0, done}, 16'h0000);
        @(negedge clock);
        start = 1'b0;
        waitDone(latency);
        checkOutput("b2b_done", {15'b0, done}, 16'h0001);
        checkOutput("b2b_result", {dut.DM1.core[7], dut.DM1.core[6]}, 16'h000F);

        // A second Start while busy is ignored; the conversion still finishes correctly.
        loadInput(16'hC880);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(latency);
        checkOutput("busy_start_done", {15'b0, done}, 16'h0001);
        checkOutput("busy_start_result", {dut.DM1.core[7], dut.DM1.core[6]}, 16'hFFF7);

        // Reset while SHIFT is still counting (0x7780 needs 15 shifts).
        loadInput(16'h7780);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_done", {15'b0, done}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("reset_abort_idle", {15'b0, sawDone}, 16'h0000);

        convert("after_reset", 16'hBD00, 16'hFFFF);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= 4 && i <= 7) continue;
`ifdef SAT_FLAG_EN
            if (i == 8) continue;
`endif
            if (dut.DM1.core[i] !== (8'(i) ^ 8'hA5)) bad++;
        end
        checkOutput("mem_untouched", 16'(bad), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
